// File: rtl/reg_control_if.sv
// ---------------------------------------------------------------------------
// reg_control_if
// Bundle of the decoded pipeline control signals around one reg_control
// stage register: the load enable, the incoming d_* bundle and the registered
// q_* bundle. clk and reset stay outside the bundle.
//   master : drives en and d_*, observes q_* (the upstream stage / a bench)
//   slave  : consumes en and d_*, produces q_* (the register itself)
// ---------------------------------------------------------------------------
interface reg_control_if #(
    parameter int MEM_OP_W = 2,
    parameter int WR_W     = 2,
    parameter int ALU_OP_W = 4
);
    logic                en;
    logic                d_cl_alu_st;
    logic                d_cl_mem_st;
    logic                d_cl_shift_op;
    logic [MEM_OP_W-1:0] d_cl_mem_op;
    logic [WR_W-1:0]     d_cl_esc_wr;
    logic [WR_W-1:0]     d_cl_vec_wr;
    logic [ALU_OP_W-1:0] d_cl_alu_op;
    logic                q_cl_alu_st;
    logic                q_cl_mem_st;
    logic                q_cl_shift_op;
    logic [MEM_OP_W-1:0] q_cl_mem_op;
    logic [WR_W-1:0]     q_cl_esc_wr;
    logic [WR_W-1:0]     q_cl_vec_wr;
    logic [ALU_OP_W-1:0] q_cl_alu_op;

    modport master (
        output en, d_cl_alu_st, d_cl_mem_st, d_cl_shift_op,
               d_cl_mem_op, d_cl_esc_wr, d_cl_vec_wr, d_cl_alu_op,
        input  q_cl_alu_st, q_cl_mem_st, q_cl_shift_op,
               q_cl_mem_op, q_cl_esc_wr, q_cl_vec_wr, q_cl_alu_op
    );

    modport slave (
        input  en, d_cl_alu_st, d_cl_mem_st, d_cl_shift_op,
               d_cl_mem_op, d_cl_esc_wr, d_cl_vec_wr, d_cl_alu_op,
        output q_cl_alu_st, q_cl_mem_st, q_cl_shift_op,
               q_cl_mem_op, q_cl_esc_wr, q_cl_vec_wr, q_cl_alu_op
    );
endinterface

// File: rtl/reg_control.sv
// ---------------------------------------------------------------------------
// reg_control
// Pipeline control-signal register for the vector CPU (e.g. decode->execute).
// Captures the decoded control bundle on every rising clk edge with en=1,
// holds it while the stage is stalled (en=0), and clears it asynchronously
// while reset is high. Every output comes straight from a flop.
//
// Ports (positional order is fixed because instances connect by position):
//   clk            in   clock, rising edge
//   en             in   load enable (1 = capture, 0 = hold)
//   reset          in   asynchronous active-high clear of all outputs
//   d_cl_alu_st    in   ALU-stage select bit
//   d_cl_mem_st    in   memory-stage select bit
//   d_cl_shift_op  in   shift-operation select
//   d_cl_mem_op    in   memory op code          [MEM_OP_W]
//   d_cl_esc_wr    in   scalar RF write control [WR_W]
//   d_cl_vec_wr    in   vector RF write control [WR_W]
//   d_cl_alu_op    in   ALU op code             [ALU_OP_W]
//   q_cl_*         out  registered copies of the matching d_cl_* inputs
// ---------------------------------------------------------------------------
module reg_control #(
    parameter int MEM_OP_W = 2,
    parameter int WR_W     = 2,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                en,
    input  logic                reset,
    input  logic                d_cl_alu_st,
    input  logic                d_cl_mem_st,
    input  logic                d_cl_shift_op,
    input  logic [MEM_OP_W-1:0] d_cl_mem_op,
    input  logic [WR_W-1:0]     d_cl_esc_wr,
    input  logic [WR_W-1:0]     d_cl_vec_wr,
    input  logic [ALU_OP_W-1:0] d_cl_alu_op,
    output logic                q_cl_alu_st,
    output logic                q_cl_mem_st,
    output logic                q_cl_shift_op,
    output logic [MEM_OP_W-1:0] q_cl_mem_op,
    output logic [WR_W-1:0]     q_cl_esc_wr,
    output logic [WR_W-1:0]     q_cl_vec_wr,
    output logic [ALU_OP_W-1:0] q_cl_alu_op
);

    logic                alu_st_d,   alu_st_q;
    logic                mem_st_d,   mem_st_q;
    logic                shift_op_d, shift_op_q;
    logic [MEM_OP_W-1:0] mem_op_d,   mem_op_q;
    logic [WR_W-1:0]     esc_wr_d,   esc_wr_q;
    logic [WR_W-1:0]     vec_wr_d,   vec_wr_q;
    logic [ALU_OP_W-1:0] alu_op_d,   alu_op_q;

    // Next state: one shared enable, so the bundle is loaded whole or not at
    // all; fields pass through without any extension or recombination.
    always_comb begin
        alu_st_d   = alu_st_q;
        mem_st_d   = mem_st_q;
        shift_op_d = shift_op_q;
        mem_op_d   = mem_op_q;
        esc_wr_d   = esc_wr_q;
        vec_wr_d   = vec_wr_q;
        alu_op_d   = alu_op_q;
        if (en) begin
            alu_st_d   = d_cl_alu_st;
            mem_st_d   = d_cl_mem_st;
            shift_op_d = d_cl_shift_op;
            mem_op_d   = d_cl_mem_op;
            esc_wr_d   = d_cl_esc_wr;
            vec_wr_d   = d_cl_vec_wr;
            alu_op_d   = d_cl_alu_op;
        end
    end

    // Reset is asynchronous and dominates en, so data presented in a cycle
    // where reset is high is never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_st_q   <= 1'b0;
            mem_st_q   <= 1'b0;
            shift_op_q <= 1'b0;
            mem_op_q   <= '0;
            esc_wr_q   <= '0;
            vec_wr_q   <= '0;
            alu_op_q   <= '0;
        end else begin
            alu_st_q   <= alu_st_d;
            mem_st_q   <= mem_st_d;
            shift_op_q <= shift_op_d;
            mem_op_q   <= mem_op_d;
            esc_wr_q   <= esc_wr_d;
            vec_wr_q   <= vec_wr_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign q_cl_alu_st   = alu_st_q;
    assign q_cl_mem_st   = mem_st_q;
    assign q_cl_shift_op = shift_op_q;
    assign q_cl_mem_op   = mem_op_q;
    assign q_cl_esc_wr   = esc_wr_q;
    assign q_cl_vec_wr   = vec_wr_q;
    assign q_cl_alu_op   = alu_op_q;

endmodule

// File: tb/tb_reg_control.sv
// ---------------------------------------------------------------------------
// tb_reg_control
// Scoreboard bench for reg_control. The driver issues one operation per
// cycle, updates a bundle-level reference model and queues the expected
// output bundle; independent monitor processes pop and compare after each
// rising edge, or between edges for asynchronous reset assertion.
// Bundle packing: {alu_st, mem_st, shift_op, mem_op[1:0], esc_wr[1:0],
//                  vec_wr[1:0], alu_op[3:0]} = 13 bits.
// ---------------------------------------------------------------------------
module tb_reg_control;

    localparam int MEM_OP_W = 2;
    localparam int WR_W     = 2;
    localparam int ALU_OP_W = 4;
    localparam int BW       = 3 + MEM_OP_W + 2 * WR_W + ALU_OP_W;

    logic clk;
    logic reset;

    reg_control_if #(.MEM_OP_W(MEM_OP_W), .WR_W(WR_W), .ALU_OP_W(ALU_OP_W)) bus ();

    reg_control #(.MEM_OP_W(MEM_OP_W), .WR_W(WR_W), .ALU_OP_W(ALU_OP_W)) dut (
        .clk           (clk),
        .en            (bus.en),
        .reset         (reset),
        .d_cl_alu_st   (bus.d_cl_alu_st),
        .d_cl_mem_st   (bus.d_cl_mem_st),
        .d_cl_shift_op (bus.d_cl_shift_op),
        .d_cl_mem_op   (bus.d_cl_mem_op),
        .d_cl_esc_wr   (bus.d_cl_esc_wr),
        .d_cl_vec_wr   (bus.d_cl_vec_wr),
        .d_cl_alu_op   (bus.d_cl_alu_op),
        .q_cl_alu_st   (bus.q_cl_alu_st),
        .q_cl_mem_st   (bus.q_cl_mem_st),
        .q_cl_shift_op (bus.q_cl_shift_op),
        .q_cl_mem_op   (bus.q_cl_mem_op),
        .q_cl_esc_wr   (bus.q_cl_esc_wr),
        .q_cl_vec_wr   (bus.q_cl_vec_wr),
        .q_cl_alu_op   (bus.q_cl_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] exp_q[$];
    string         tag_q[$];
    logic [BW-1:0] model;     // what the stage register should be holding
    event          async_ev;

    function automatic logic [BW-1:0] pack(input int a, input int b, input int c,
                                           input int mo, input int ew, input int vw,
                                           input int ao);
        logic [BW-1:0] v;
        v = {a[0], b[0], c[0], mo[MEM_OP_W-1:0], ew[WR_W-1:0], vw[WR_W-1:0],
             ao[ALU_OP_W-1:0]};
        return v;
    endfunction

    function automatic logic [BW-1:0] observed();
        return {bus.q_cl_alu_st, bus.q_cl_mem_st, bus.q_cl_shift_op, bus.q_cl_mem_op,
                bus.q_cl_esc_wr, bus.q_cl_vec_wr, bus.q_cl_alu_op};
    endfunction

    task automatic drive_d(input logic [BW-1:0] v);
        {bus.d_cl_alu_st, bus.d_cl_mem_st, bus.d_cl_shift_op, bus.d_cl_mem_op,
         bus.d_cl_esc_wr, bus.d_cl_vec_wr, bus.d_cl_alu_op} = v;
    endtask

    // One clock of stimulus: inputs change on the falling edge, the model
    // states what the next rising edge must leave in the register.
    task automatic step(input logic r, input logic e, input logic [BW-1:0] v,
                        input string tag);
        @(negedge clk);
        reset  = r;
        bus.en = e;
        drive_d(v);
        if (r)      model = '0;
        else if (e) model = v;
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(posedge clk);
    endtask

    // Raise reset between edges; the clear must be visible before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.en = 1'b1;
        drive_d(pack(1, 1, 1, 3, 3, 3, 15));
        reset = 1'b1;
        model = '0;
        exp_q.push_back(model);
        tag_q.push_back(tag);
        -> async_ev;
        #2;
    endtask

    task automatic check_now();
        logic [BW-1:0] act;
        logic [BW-1:0] exp;
        string         tag;
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        act = observed();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: q bundle got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check_now();
    end

    always @(async_ev) begin
        #1;
        check_now();
    end

    initial begin
        logic [BW-1:0] v;
        logic [BW-1:0] stall_v;
        logic [BW-1:0] one;
        reset  = 1'b1;
        bus.en = 1'b1;
        model  = '0;
        drive_d(pack(1, 1, 1, 3, 3, 3, 15));

        // Reset held with en=1 and non-zero inputs.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, pack(1, 1, 1, 3, 3, 3, 15), "reset_hold");
        // Deassert with en=0: must stay cleared.
        step(1'b0, 1'b0, pack(1, 0, 1, 2, 1, 3, 9), "post_reset_hold");

        step(1'b0, 1'b1, pack(1, 1, 0, 2, 2, 1, 3), "normal_load");
        stall_v = pack(0, 0, 1, 3, 3, 0, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, stall_v, "stall");
        step(1'b0, 1'b1, stall_v, "resume");

        // Data changing every enabled cycle.
        for (int i = 0; i < 20; i++) begin
            v = BW'($urandom);
            step(1'b0, 1'b1, v, "back_to_back");
        end

        async_reset("async_clear");
        step(1'b1, 1'b1, pack(1, 1, 1, 3, 3, 3, 15), "reset_beats_en");
        step(1'b0, 1'b0, pack(0, 1, 0, 1, 1, 1, 7), "deassert_hold");
        step(1'b0, 1'b1, pack(0, 1, 0, 1, 1, 1, 7), "first_load_after_reset");

        step(1'b0, 1'b1, pack(1, 1, 1, 3, 3, 3, 15), "all_ones");
        step(1'b0, 1'b1, '0, "all_zeros");
        for (int i = 0; i < BW; i++) begin
            one = '0;
            one[i] = 1'b1;
            step(1'b0, 1'b1, one, "walking_one");
        end
        one = '1;
        for (int i = 0; i < BW; i++) begin
            v = one;
            v[i] = 1'b0;
            step(1'b0, 1'b1, v, "walking_zero");
        end

        // Mixed random traffic: random stalls and occasional reset pulses.
        for (int i = 0; i < 150; i++) begin
            v = BW'($urandom);
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, v, "random_mix");
        end

        // Another stall after a known load, long run.
        step(1'b0, 1'b1, pack(1, 0, 1, 1, 2, 3, 10), "pre_long_stall");
        for (int i = 0; i < 10; i++) begin
            v = BW'($urandom);
            step(1'b0, 1'b0, v, "long_stall");
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
